// File: rtl/core_pkg.sv
// core_pkg -- definitions shared by the fetch stage and its buffer.
//   XLEN             : architectural word width.
//   DEFAULT_RESET_PC : default first fetch address.
//   NOP_INST         : canonical NOP encoding (addi x0, x0, 0).
//   fetch_entry_t    : one instruction-buffer entry {pc, inst, misalign}.
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            misalign;
  } fetch_entry_t;

  // Clears the byte-offset bits of a fetch address.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo -- small circular FIFO used for the instruction buffer and the
// in-flight PC queue of the fetch stage.
// Parameters: DEPTH (entries, >= 2), entry_t (stored type).
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : drop all entries; a push in the same cycle becomes the sole entry
//   push       : write push_data at the tail
//   push_data  : entry to write
//   pop        : advance the head (ignored when empty)
//   head       : oldest entry, all-zero when empty
//   count      : number of valid entries
module fetch_fifo
  import core_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic          pop_ok, push_ok;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop_ok  = pop && (cnt_q != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && ((cnt_q != CW'(DEPTH)) || pop_ok);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    mem_d = mem_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
      if (push) begin
        mem_d[0] = push_data;
        wr_d     = PW'(1);
        cnt_d    = CW'(1);
      end
    end else begin
      if (push_ok) begin
        mem_d[wr_q] = push_data;
        wr_d        = next_ptr(wr_q);
      end
      if (pop_ok) rd_d = next_ptr(rd_q);
      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

  assign head  = (cnt_q != '0) ? mem_q[rd_q] : '0;
  assign count = cnt_q;

endmodule

// File: rtl/if_stage.sv
// if_stage -- instruction fetch: issues word fetches, tracks outstanding
// requests, buffers returned instructions for decode and handles redirects.
// Optional feature macro: IF_MISALIGN_TRAP_EN (misaligned redirect produces a
// trap entry and halts fetch instead of silently aligning the target).
// Parameters: RESET_PC (first fetch address), BUF_DEPTH (2..8, buffer size and
//             cap on in-flight plus buffered fetches).
// Ports:
//   clk, rst                        : clock, asynchronous active-high reset
//   imem_req_valid/ready/addr       : fetch request channel
//   imem_rsp_valid/data             : in-order fetch responses, always accepted
//   redirect_valid/pc               : branch/jump/trap redirect
//   id_valid/ready, id_inst, id_pc  : instruction handed to decode
//   id_misalign                     : trap entry flag (IF_MISALIGN_TRAP_EN only)
module if_stage
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic            id_misalign
`endif
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [XLEN-1:0] pc_q, pc_d;
  // inflight counts every outstanding request, including ones to be dropped;
  // drop counts how many of the oldest outstanding responses are stale.
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic            halted;

  logic            fire;
  logic [CW:0]     occupancy;
  logic            buf_push, buf_flush, buf_pop;
  fetch_entry_t    buf_entry, buf_head;
  logic [CW-1:0]   buf_count;
  logic            pcq_push, pcq_pop, pcq_flush;
  logic [XLEN-1:0] pcq_head;
  logic [CW-1:0]   pcq_count;

`ifdef IF_MISALIGN_TRAP_EN
  logic halt_q, halt_d;
  assign halted = halt_q;
`else
  assign halted = 1'b0;
`endif

  assign occupancy      = (CW + 1)'(inflight_q) + (CW + 1)'(buf_count);
  assign imem_req_valid = !rst && !redirect_valid && !halted &&
                          (occupancy < (CW + 1)'(BUF_DEPTH));
  assign imem_req_addr  = pc_q;
  assign fire           = imem_req_valid && imem_req_ready;
  assign buf_pop        = id_valid && id_ready;

  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    buf_push   = 1'b0;
    buf_flush  = 1'b0;
    buf_entry  = '0;
    pcq_push   = 1'b0;
    pcq_pop    = 1'b0;
    pcq_flush  = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
    halt_d     = halt_q;
`endif

    case ({fire, imem_rsp_valid})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    if (redirect_valid) begin
      // Everything still outstanding after this edge is stale; a response
      // arriving right now is discarded rather than buffered.
      buf_flush = 1'b1;
      pcq_flush = 1'b1;
      drop_d    = inflight_q - CW'(imem_rsp_valid);
      pc_d      = word_align(redirect_pc);
`ifdef IF_MISALIGN_TRAP_EN
      halt_d = 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        buf_push           = 1'b1;
        buf_entry.pc       = redirect_pc;
        buf_entry.misalign = 1'b1;
        halt_d             = 1'b1;
      end
`endif
    end else begin
      if (fire) begin
        pc_d     = pc_q + XLEN'(4);
        pcq_push = 1'b1;
      end
      if (imem_rsp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else if (pcq_count != '0) begin
          pcq_pop        = 1'b1;
          buf_push       = 1'b1;
          buf_entry.pc   = pcq_head;
          buf_entry.inst = imem_rsp_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) halt_q <= 1'b0;
    else     halt_q <= halt_d;
  end
`endif

  fetch_fifo #(
    .DEPTH   (BUF_DEPTH),
    .entry_t (logic [XLEN-1:0])
  ) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (pcq_flush),
    .push      (pcq_push),
    .push_data (pc_q),
    .pop       (pcq_pop),
    .head      (pcq_head),
    .count     (pcq_count)
  );

  fetch_fifo #(
    .DEPTH   (BUF_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_inst_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (buf_flush),
    .push      (buf_push),
    .push_data (buf_entry),
    .pop       (buf_pop),
    .head      (buf_head),
    .count     (buf_count)
  );

  assign id_valid = (buf_count != '0);
  assign id_inst  = buf_head.inst;
  assign id_pc    = buf_head.pc;

`ifdef IF_MISALIGN_TRAP_EN
  assign id_misalign = buf_head.misalign;
`else
  logic unused_misalign;
  assign unused_misalign = buf_head.misalign;
`endif

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
`ifdef IF_MISALIGN_TRAP_EN
  logic        id_misalign;
`endif

  if_stage #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc)
`ifdef IF_MISALIGN_TRAP_EN
    ,
    .id_misalign    (id_misalign)
`endif
  );

  always #5 clk = ~clk;

  int           n_tests  = 0;
  int           n_fail   = 0;
  int           fire_cnt = 0;
  logic         rsp_hold = 1'b0;
  fetch_entry_t exp_q[$];
  logic [31:0]  mem_q[$];
  logic [31:0]  req_log[$];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A00_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic exp_push(input logic [31:0] pc);
    fetch_entry_t e;
    e.pc       = pc;
    e.inst     = inst_of(pc);
    e.misalign = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic check_delivery();
    fetch_entry_t e;
    logic         act_mis;
`ifdef IF_MISALIGN_TRAP_EN
    act_mis = id_misalign;
`else
    act_mis = 1'b0;
`endif
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL deliver: got unexpected pc=%h inst=%h, required no delivery", id_pc, id_inst);
    end else begin
      e = exp_q.pop_front();
      if (id_pc !== e.pc || id_inst !== e.inst || act_mis !== e.misalign) begin
        n_fail++;
        $display("FAIL deliver: got pc=%h inst=%h mis=%b, required pc=%h inst=%h mis=%b",
                 id_pc, id_inst, act_mis, e.pc, e.inst, e.misalign);
      end
    end
  endtask

  // Memory model: answers each accepted request one cycle later, in order.
  always @(negedge clk) begin
    if (!rst && !rsp_hold && mem_q.size() != 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst_of(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  // Request recorder and delivery monitor, sampled 1 ns before the rising edge.
  always @(negedge clk) begin
    #4;
    if (rst) begin
      mem_q.delete();
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        mem_q.push_back(imem_req_addr);
        req_log.push_back(imem_req_addr);
        fire_cnt++;
      end
      if (id_valid && id_ready) check_delivery();
    end
  end

  task automatic drain(input string nm);
    int k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: got %0d deliveries still pending after %0d cycles, required 0",
               nm, exp_q.size(), k);
      exp_q.delete();
    end
    id_ready = 1'b0;
  endtask

  task automatic redir(input logic [31:0] target);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;

    // Reset values
    repeat (3) @(negedge clk);
    #4;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_id_valid", 32'(id_valid), 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_inst", id_inst, 32'h0);

    // Reset release: first request at RESET_PC, in-order delivery
    @(negedge clk);
    rst = 1'b0;
    req_log.delete();
    exp_push(32'h0); exp_push(32'h4); exp_push(32'h8);
    id_ready = 1'b1;
    #4;
    chk("rel_req_valid", 32'(imem_req_valid), 32'h1);
    chk("rel_req_addr", imem_req_addr, 32'h0);
    drain("rel_drain");
    for (int i = 0; i < 3; i++)
      chk("rel_req_seq", (req_log.size() > i) ? req_log[i] : 32'hDEAD_BEEF, 32'(i * 4));

    // Decode backpressure for 10 cycles
    f0 = fire_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #4;
      if (i >= 3) begin
        chk("bp_id_valid", 32'(id_valid), 32'h1);
        chk("bp_id_pc", id_pc, 32'hC);
        chk("bp_id_inst", id_inst, inst_of(32'hC));
      end
    end
    chk("bp_fire_cap", 32'(fire_cnt - f0 <= 2), 32'h1);
    @(negedge clk);
    exp_push(32'hC); exp_push(32'h10); exp_push(32'h14);
    id_ready = 1'b1;
    drain("bp_drain");

    // Redirect with two requests in flight
    repeat (5) @(negedge clk);
    @(negedge clk);
    rsp_hold       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (3) @(negedge clk);
    #4;
    chk("rd_cap_valid", 32'(imem_req_valid), 32'h0);
    chk("rd_last_req", (req_log.size() != 0) ? req_log[$] : 32'hDEAD_BEEF, 32'h84);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    rsp_hold       = 1'b0;
    exp_push(32'h100); exp_push(32'h104);
    id_ready = 1'b1;
    drain("rd_drain");

    // Redirect in the same cycle as the handshake of 0x8
    redir(32'h8);
    repeat (6) @(negedge clk);
    #4;
    chk("hs_id_valid", 32'(id_valid), 32'h1);
    chk("hs_id_pc", id_pc, 32'h8);
    @(negedge clk);
    exp_push(32'h8); exp_push(32'h300); exp_push(32'h304);
    id_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    @(negedge clk);
    redirect_valid = 1'b0;
    drain("hs_drain");

    // Memory not ready for 5 cycles
    @(negedge clk);
    imem_req_ready = 1'b0;
    redir(32'h400);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #4;
      chk("nr_req_addr", imem_req_addr, 32'h400);
      chk("nr_id_valid", 32'(id_valid), 32'h0);
    end
    @(negedge clk);
    imem_req_ready = 1'b1;
    exp_push(32'h400); exp_push(32'h404);
    id_ready = 1'b1;
    drain("nr_drain");

    // Back-to-back redirects with stale responses landing on redirect cycles
    repeat (5) @(negedge clk);
    @(negedge clk);
    rsp_hold       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h500;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    rsp_hold       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h600;
    @(negedge clk);
    redirect_pc    = 32'h700;
    @(negedge clk);
    redirect_valid = 1'b0;
    exp_push(32'h700); exp_push(32'h704);
    id_ready = 1'b1;
    drain("b2b_drain");

`ifdef IF_MISALIGN_TRAP_EN
    // Misaligned redirect: single trap entry, fetch halted until next redirect
    begin
      fetch_entry_t e;
      redir(32'h102);
      e.pc       = 32'h102;
      e.inst     = 32'h0;
      e.misalign = 1'b1;
      exp_q.push_back(e);
      id_ready = 1'b1;
      drain("mis_drain");
      f0 = fire_cnt;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        #4;
        chk("mis_req_valid", 32'(imem_req_valid), 32'h0);
      end
      chk("mis_no_fetch", 32'(fire_cnt - f0), 32'h0);
      redir(32'h200);
      exp_push(32'h200);
      id_ready = 1'b1;
      drain("mis_resume");
    end
`else
    // Misaligned redirect target is word-aligned
    redir(32'h103);
    exp_push(32'h100); exp_push(32'h104);
    id_ready = 1'b1;
    drain("align_drain");
`endif

    // Reset in the middle of operation
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #4;
    chk("mid_rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("mid_rst_id_valid", 32'(id_valid), 32'h0);
    chk("mid_rst_id_pc", id_pc, 32'h0);
    chk("mid_rst_req_addr", imem_req_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_push(32'h0); exp_push(32'h4);
    id_ready = 1'b1;
    drain("mid_rst_drain");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
